ddr3_port_initiator: RTL and testbench

Initiator for one Artemis DDR3 MCB user port (cmd/wr/rd FIFO triplet). Converts a single-request transaction interface (address, length, direction) into the MCB sequence: write-FIFO fill, command push, read-FIFO drain. Sits between a Wishbone/host slave and the MCB port, in the same clock domain as the port clocks. Also monitors port error flags and bounds each transaction with a watchdog.

---
 rtl/ddr3_port_initiator.sv | 188 ++++++++++++++++++
 tb/tb_ddr3_port_initiator.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_port_initiator.sv
// Single-request initiator for one MCB user port: write-FIFO fill, command push, read-FIFO drain.
// Optional feature macro: DDR3_INIT_WR_FLUSH_EN holds write completion until the write FIFO is empty.
module ddr3_port_initiator #(
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        calibration_done,
    input  logic        req_stb,
    input  logic        req_write,
    input  logic [29:0] req_addr,
    input  logic [6:0]  req_len,
    output logic        req_ack,
    output logic        busy,
    output logic        done,
    output logic [3:0]  status,
    input  logic        usr_wr_valid,
    output logic        usr_wr_ready,
    input  logic [31:0] usr_wr_data,
    output logic        usr_rd_valid,
    output logic [31:0] usr_rd_data,
    output logic        p_cmd_en,
    output logic [2:0]  p_cmd_instr,
    output logic [5:0]  p_cmd_bl,
    output logic [29:0] p_cmd_byte_addr,
    input  logic        p_cmd_full,
    input  logic        p_cmd_empty,
    output logic        p_wr_en,
    output logic [3:0]  p_wr_mask,
    output logic [31:0] p_wr_data,
    input  logic        p_wr_full,
    input  logic        p_wr_empty,
    input  logic        p_wr_underrun,
    input  logic        p_wr_error,
    output logic        p_rd_en,
    input  logic [31:0] p_rd_data,
    input  logic        p_rd_empty,
    input  logic        p_rd_overflow,
    input  logic        p_rd_error
);

    typedef enum logic [2:0] {
        IDLE, WR_FILL, WR_CMD, WR_FLUSH, RD_CMD, RD_DRAIN, DONE
    } state_t;

    localparam bit          WD_EN   = (TIMEOUT > 0);
    localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

    state_t      state_reg;
    logic [29:0] addr_reg;
    logic [6:0]  len_reg;
    logic [6:0]  cnt_reg;
    logic [31:0] wd_reg;
    logic [3:0]  status_reg;
    logic        usr_rd_valid_reg;
    logic [31:0] usr_rd_data_reg;

    logic [6:0]  len_eff;
    logic        in_cmd;
    logic        wr_beat;
    logic        rd_pop;
    logic        cmd_push;
    logic        flush_exit;
    logic        last_word;
    logic        unused_ok;

    always_comb begin
        len_eff = req_len;
        if (req_len == 7'd0)
            len_eff = 7'd1;
        else if (req_len > 7'd64)
            len_eff = 7'd64;
    end

    // Port strobes are gated by rst so a reset cycle never moves data.
    assign in_cmd       = (state_reg == WR_CMD) || (state_reg == RD_CMD);
    assign req_ack      = !rst && (state_reg == IDLE) && req_stb && calibration_done;
    assign busy         = (state_reg != IDLE);
    assign done         = (state_reg == DONE);
    assign usr_wr_ready = (state_reg == WR_FILL) && !p_wr_full;
    assign wr_beat      = !rst && usr_wr_ready && usr_wr_valid;
    assign cmd_push     = !rst && in_cmd && !p_cmd_full;
    assign rd_pop       = !rst && (state_reg == RD_DRAIN) && !p_rd_empty;
    assign last_word    = (cnt_reg + 7'd1) == len_reg;

    assign p_wr_en         = wr_beat;
    assign p_wr_mask       = 4'b0000;
    assign p_wr_data       = (state_reg == WR_FILL) ? usr_wr_data : 32'd0;
    assign p_cmd_en        = cmd_push;
    assign p_cmd_instr     = (state_reg == RD_CMD) ? 3'b001 : 3'b000;
    assign p_cmd_bl        = in_cmd ? 6'(len_reg - 7'd1) : 6'd0;
    assign p_cmd_byte_addr = in_cmd ? addr_reg : 30'd0;
    assign p_rd_en         = rd_pop;

    assign status       = status_reg;
    assign usr_rd_valid = usr_rd_valid_reg;
    assign usr_rd_data  = usr_rd_data_reg;

`ifdef DDR3_INIT_WR_FLUSH_EN
    assign flush_exit = (state_reg == WR_FLUSH) && p_wr_empty;
`else
    assign flush_exit = 1'b0;
`endif

    assign unused_ok = ^{p_cmd_empty, p_wr_empty};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            addr_reg         <= '0;
            len_reg          <= '0;
            cnt_reg          <= '0;
            wd_reg           <= '0;
            status_reg       <= '0;
            usr_rd_valid_reg <= 1'b0;
            usr_rd_data_reg  <= '0;
        end else begin
            usr_rd_valid_reg <= rd_pop;
            if (rd_pop)
                usr_rd_data_reg <= p_rd_data;
            if (busy)
                status_reg <= status_reg |
                              {1'b0, p_rd_error | p_rd_overflow, p_wr_error, p_wr_underrun};

            case (state_reg)
                IDLE: begin
                    if (req_ack) begin
                        addr_reg   <= {req_addr[29:2], 2'b00};
                        len_reg    <= len_eff;
                        cnt_reg    <= '0;
                        status_reg <= '0;
                        state_reg  <= req_write ? WR_FILL : RD_CMD;
                    end
                end
                WR_FILL: begin
                    if (wr_beat) begin
                        cnt_reg <= cnt_reg + 7'd1;
                        if (last_word)
                            state_reg <= WR_CMD;
                    end
                end
                WR_CMD: begin
                    if (cmd_push) begin
`ifdef DDR3_INIT_WR_FLUSH_EN
                        state_reg <= WR_FLUSH;
`else
                        state_reg <= DONE;
`endif
                    end
                end
`ifdef DDR3_INIT_WR_FLUSH_EN
                WR_FLUSH: begin
                    if (flush_exit)
                        state_reg <= DONE;
                end
`endif
                RD_CMD: begin
                    if (cmd_push) begin
                        cnt_reg   <= '0;
                        state_reg <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (rd_pop) begin
                        cnt_reg <= cnt_reg + 7'd1;
                        if (last_word)
                            state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase

            // Watchdog restarts on any progress; expiry aborts without issuing a command.
            if ((state_reg == IDLE) || (state_reg == DONE) ||
                wr_beat || rd_pop || cmd_push || flush_exit) begin
                wd_reg <= '0;
            end else if (WD_EN && (wd_reg == WD_LAST)) begin
                wd_reg        <= '0;
                status_reg[3] <= 1'b1;
                state_reg     <= DONE;
            end else begin
                wd_reg <= wd_reg + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_port_initiator.sv
// Directed bench for ddr3_port_initiator: one task per scenario, inline checks, one summary line.
// A second instance with TIMEOUT = 16 covers the watchdog scenario.
module tb_ddr3_port_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        calibration_done = 1'b1;
    logic        req_stb = 1'b0;
    logic        req_stb_wd = 1'b0;
    logic        req_write = 1'b0;
    logic [29:0] req_addr = '0;
    logic [6:0]  req_len = '0;
    logic        usr_wr_valid = 1'b0;
    logic [31:0] usr_wr_data = '0;
    logic        p_cmd_full = 1'b0;
    logic        p_cmd_empty = 1'b1;
    logic        p_wr_full = 1'b0;
    logic        p_wr_empty = 1'b1;
    logic        p_wr_underrun = 1'b0;
    logic        p_wr_error = 1'b0;
    logic [31:0] p_rd_data = '0;
    logic        p_rd_empty = 1'b1;
    logic        p_rd_overflow = 1'b0;
    logic        p_rd_error = 1'b0;

    logic        req_ack, busy, done, usr_wr_ready, usr_rd_valid;
    logic [3:0]  status;
    logic [31:0] usr_rd_data;
    logic        p_cmd_en, p_wr_en, p_rd_en;
    logic [2:0]  p_cmd_instr;
    logic [5:0]  p_cmd_bl;
    logic [29:0] p_cmd_byte_addr;
    logic [3:0]  p_wr_mask;
    logic [31:0] p_wr_data;

    logic        wd_req_ack, wd_busy, wd_done, wd_usr_wr_ready, wd_usr_rd_valid;
    logic [3:0]  wd_status;
    logic [31:0] wd_usr_rd_data;
    logic        wd_p_cmd_en, wd_p_wr_en, wd_p_rd_en;
    logic [2:0]  wd_p_cmd_instr;
    logic [5:0]  wd_p_cmd_bl;
    logic [29:0] wd_p_cmd_byte_addr;
    logic [3:0]  wd_p_wr_mask;
    logic [31:0] wd_p_wr_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_seen [$];
    logic [31:0] rd_seen [$];
    int done_cnt = 0;
    int cmd_cnt = 0;
    int prot_viol = 0;

    always #5 clk = ~clk;

    ddr3_port_initiator dut (
        .clk(clk), .rst(rst), .calibration_done(calibration_done),
        .req_stb(req_stb), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_ack(req_ack), .busy(busy), .done(done), .status(status),
        .usr_wr_valid(usr_wr_valid), .usr_wr_ready(usr_wr_ready), .usr_wr_data(usr_wr_data),
        .usr_rd_valid(usr_rd_valid), .usr_rd_data(usr_rd_data),
        .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr), .p_cmd_bl(p_cmd_bl),
        .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full), .p_cmd_empty(p_cmd_empty),
        .p_wr_en(p_wr_en), .p_wr_mask(p_wr_mask), .p_wr_data(p_wr_data),
        .p_wr_full(p_wr_full), .p_wr_empty(p_wr_empty), .p_wr_underrun(p_wr_underrun),
        .p_wr_error(p_wr_error), .p_rd_en(p_rd_en), .p_rd_data(p_rd_data),
        .p_rd_empty(p_rd_empty), .p_rd_overflow(p_rd_overflow), .p_rd_error(p_rd_error)
    );

    ddr3_port_initiator #(.TIMEOUT(16)) dut_wd (
        .clk(clk), .rst(rst), .calibration_done(calibration_done),
        .req_stb(req_stb_wd), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_ack(wd_req_ack), .busy(wd_busy), .done(wd_done), .status(wd_status),
        .usr_wr_valid(usr_wr_valid), .usr_wr_ready(wd_usr_wr_ready), .usr_wr_data(usr_wr_data),
        .usr_rd_valid(wd_usr_rd_valid), .usr_rd_data(wd_usr_rd_data),
        .p_cmd_en(wd_p_cmd_en), .p_cmd_instr(wd_p_cmd_instr), .p_cmd_bl(wd_p_cmd_bl),
        .p_cmd_byte_addr(wd_p_cmd_byte_addr), .p_cmd_full(p_cmd_full), .p_cmd_empty(p_cmd_empty),
        .p_wr_en(wd_p_wr_en), .p_wr_mask(wd_p_wr_mask), .p_wr_data(wd_p_wr_data),
        .p_wr_full(p_wr_full), .p_wr_empty(p_wr_empty), .p_wr_underrun(p_wr_underrun),
        .p_wr_error(p_wr_error), .p_rd_en(wd_p_rd_en), .p_rd_data(p_rd_data),
        .p_rd_empty(p_rd_empty), .p_rd_overflow(p_rd_overflow), .p_rd_error(p_rd_error)
    );

    // Port monitor on the main instance; inputs change just after posedge, so negedge is stable.
    always @(negedge clk) begin
        if (p_wr_en) wr_seen.push_back(p_wr_data);
        if (usr_rd_valid) rd_seen.push_back(usr_rd_data);
        if (done) done_cnt++;
        if (p_cmd_en) cmd_cnt++;
        if ((p_cmd_en && p_cmd_full) || (p_wr_en && (p_wr_full || p_wr_mask != 4'b0000)) ||
            (p_rd_en && p_rd_empty))
            prot_viol++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({busy, req_ack, done, usr_wr_ready, usr_rd_valid, p_cmd_en, p_wr_en, p_rd_en} !== 8'd0) begin
            errors++;
            $display("FAIL reset_strobes got %b want 00000000",
                     {busy, req_ack, done, usr_wr_ready, usr_rd_valid, p_cmd_en, p_wr_en, p_rd_en});
        end
        checks++;
        if ({status, usr_rd_data, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr, p_wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_values status=%h rd_data=%h instr=%h bl=%h addr=%h wr_data=%h want all 0",
                     status, usr_rd_data, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr, p_wr_data);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_write4();
        int wr_base = wr_seen.size();
        int done_base = done_cnt;
        int cmd_base = cmd_cnt;
        req_stb = 1'b1; req_write = 1'b1; req_addr = 30'h100; req_len = 7'd4;
        @(negedge clk);
        checks++;
        if (req_ack !== 1'b1) begin errors++; $display("FAIL wr4_ack got %b want 1", req_ack); end
        step();
        req_stb = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            usr_wr_valid = 1'b1; usr_wr_data = 32'(i);
            @(negedge clk);
            checks++;
            if (usr_wr_ready !== 1'b1) begin errors++; $display("FAIL wr4_ready beat %0d got %b want 1", i, usr_wr_ready); end
            step();
        end
        usr_wr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr} !== {1'b1, 3'b000, 6'd3, 30'h100}) begin
            errors++;
            $display("FAIL wr4_cmd got en=%b instr=%b bl=%0d addr=%h want en=1 instr=000 bl=3 addr=100",
                     p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if ({done, status} !== {1'b1, 4'b0000}) begin
            errors++; $display("FAIL wr4_done got done=%b status=%b want done=1 status=0000", done, status);
        end
        step();
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL wr4_idle got busy=%b done=%b want 0 0", busy, done); end
        step();
        checks++;
        if ((wr_seen.size() - wr_base) != 4 || cmd_cnt - cmd_base != 1 || done_cnt - done_base != 1) begin
            errors++;
            $display("FAIL wr4_counts got beats=%0d cmds=%0d dones=%0d want 4 1 1",
                     wr_seen.size() - wr_base, cmd_cnt - cmd_base, done_cnt - done_base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_seen[wr_base + i] !== 32'(i + 1)) begin
                    errors++; $display("FAIL wr4_data beat %0d got %h want %h", i, wr_seen[wr_base + i], i + 1);
                end
            end
        end
    endtask

    task automatic test_read3();
        logic        emp [9];
        logic [31:0] dat [9];
        int rd_base = rd_seen.size();
        emp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        dat = '{32'h0, 32'h0, 32'hA, 32'h0, 32'hB, 32'h0, 32'h0, 32'h0, 32'hC};
        req_stb = 1'b1; req_write = 1'b0; req_addr = 30'h200; req_len = 7'd3;
        @(negedge clk);
        checks++;
        if (req_ack !== 1'b1) begin errors++; $display("FAIL rd3_ack got %b want 1", req_ack); end
        step();
        req_stb = 1'b0;
        @(negedge clk);
        checks++;
        if ({p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr} !== {1'b1, 3'b001, 6'd2, 30'h200}) begin
            errors++;
            $display("FAIL rd3_cmd got en=%b instr=%b bl=%0d addr=%h want en=1 instr=001 bl=2 addr=200",
                     p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr);
        end
        step();
        for (int i = 0; i < 9; i++) begin
            p_rd_empty = emp[i]; p_rd_data = dat[i]; p_rd_overflow = (i == 0);
            @(negedge clk);
            checks++;
            if (p_rd_en !== !emp[i]) begin errors++; $display("FAIL rd3_rd_en slot %0d got %b want %b", i, p_rd_en, !emp[i]); end
            step();
        end
        p_rd_empty = 1'b1; p_rd_overflow = 1'b0; p_rd_data = '0;
        @(negedge clk);
        checks++;
        if ({done, usr_rd_valid, usr_rd_data, status} !== {1'b1, 1'b1, 32'hC, 4'b0100}) begin
            errors++;
            $display("FAIL rd3_done got done=%b valid=%b data=%h status=%b want 1 1 0000000c 0100",
                     done, usr_rd_valid, usr_rd_data, status);
        end
        step();
        checks++;
        if (rd_seen.size() - rd_base != 3) begin
            errors++; $display("FAIL rd3_count got %0d want 3", rd_seen.size() - rd_base);
        end else begin
            checks++;
            if ({rd_seen[rd_base], rd_seen[rd_base + 1], rd_seen[rd_base + 2]} !== {32'hA, 32'hB, 32'hC}) begin
                errors++;
                $display("FAIL rd3_data got %h %h %h want a b c", rd_seen[rd_base], rd_seen[rd_base + 1], rd_seen[rd_base + 2]);
            end
        end
    endtask

    task automatic test_len64_stall();
        int wr_base = wr_seen.size();
        int sent = 0;
        int rdy_low = 0;
        req_stb = 1'b1; req_write = 1'b1; req_addr = 30'h0; req_len = 7'd64;
        @(negedge clk);
        step();
        req_stb = 1'b0;
        for (int c = 0; c < 200 && sent < 64; c++) begin
            p_wr_full = (c >= 20 && c < 30);
            p_wr_error = (c == 5);
            usr_wr_valid = 1'b1; usr_wr_data = 32'(sent + 1);
            @(negedge clk);
            if (!usr_wr_ready) rdy_low++;
            if (p_wr_en) sent++;
            step();
        end
        usr_wr_valid = 1'b0; p_wr_full = 1'b0; p_wr_error = 1'b0;
        @(negedge clk);
        checks++;
        if ({p_cmd_en, p_cmd_instr, p_cmd_bl} !== {1'b1, 3'b000, 6'd63}) begin
            errors++; $display("FAIL len64_cmd got en=%b instr=%b bl=%0d want 1 000 63", p_cmd_en, p_cmd_instr, p_cmd_bl);
        end
        step();
        @(negedge clk);
        checks++;
        if ({done, status} !== {1'b1, 4'b0010}) begin
            errors++; $display("FAIL len64_done got done=%b status=%b want 1 0010", done, status);
        end
        step();
        checks++;
        if (rdy_low != 10) begin errors++; $display("FAIL len64_ready_low got %0d want 10", rdy_low); end
        checks++;
        if (wr_seen.size() - wr_base != 64) begin
            errors++; $display("FAIL len64_beats got %0d want 64", wr_seen.size() - wr_base);
        end else begin
            int bad = 0;
            for (int i = 0; i < 64; i++)
                if (wr_seen[wr_base + i] !== 32'(i + 1)) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL len64_data got %0d wrong beats want 0", bad); end
        end
    endtask

    task automatic test_cmd_full();
        int held = 0;
        int wr_base = wr_seen.size();
        req_stb = 1'b1; req_write = 1'b1; req_addr = 30'h47; req_len = 7'd0;
        @(negedge clk);
        step();
        req_stb = 1'b0;
        usr_wr_valid = 1'b1; usr_wr_data = 32'h99; p_cmd_full = 1'b1;
        @(negedge clk);
        step();
        usr_wr_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p_cmd_en || !busy || done) held++;
            step();
        end
        checks++;
        if (held != 0) begin errors++; $display("FAIL cmdfull_holdoff got %0d bad cycles want 0", held); end
        p_cmd_full = 1'b0;
        @(negedge clk);
        checks++;
        if ({p_cmd_en, p_cmd_bl, p_cmd_byte_addr} !== {1'b1, 6'd0, 30'h44}) begin
            errors++; $display("FAIL cmdfull_issue got en=%b bl=%0d addr=%h want 1 0 44", p_cmd_en, p_cmd_bl, p_cmd_byte_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL cmdfull_done got %b want 1", done); end
        step();
        checks++;
        if (wr_seen.size() - wr_base != 1 || wr_seen[wr_seen.size() - 1] !== 32'h99) begin
            errors++; $display("FAIL cmdfull_beats got %0d beats want 1 beat of 99", wr_seen.size() - wr_base);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        req_stb_wd = 1'b1; req_write = 1'b0; req_addr = 30'h0; req_len = 7'd2;
        @(negedge clk);
        checks++;
        if (wd_req_ack !== 1'b1) begin errors++; $display("FAIL wd_ack got %b want 1", wd_req_ack); end
        step();
        req_stb_wd = 1'b0;
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (wd_done) break;
            step();
        end
        checks++;
        if (n != 18 || wd_status !== 4'b1000) begin
            errors++; $display("FAIL wd_expire got done at cycle %0d status=%b want 18 1000", n, wd_status);
        end
        step();
        @(negedge clk);
        checks++;
        if (wd_busy !== 1'b0) begin errors++; $display("FAIL wd_idle got busy=%b want 0", wd_busy); end
        step();
        req_stb_wd = 1'b1; req_len = 7'd1;
        @(negedge clk);
        checks++;
        if ({wd_req_ack, wd_status} !== {1'b1, 4'b1000}) begin
            errors++; $display("FAIL wd_reack got ack=%b status=%b want 1 1000", wd_req_ack, wd_status);
        end
        step();
        req_stb_wd = 1'b0;
        @(negedge clk);
        checks++;
        if (wd_status !== 4'b0000) begin errors++; $display("FAIL wd_clear got %b want 0000", wd_status); end
        for (n = 0; n < 40; n++) begin
            if (wd_done) break;
            step();
            @(negedge clk);
        end
        checks++;
        if (wd_done !== 1'b1) begin errors++; $display("FAIL wd_second got no done within 40 cycles"); end
        step();
    endtask

    task automatic test_reset_mid();
        int wr_base;
        req_stb = 1'b1; req_write = 1'b0; req_addr = 30'h300; req_len = 7'd100;
        @(negedge clk);
        step();
        req_stb = 1'b0;
        @(negedge clk);
        checks++;
        if ({p_cmd_en, p_cmd_instr, p_cmd_bl} !== {1'b1, 3'b001, 6'd63}) begin
            errors++; $display("FAIL rstmid_clamp got en=%b instr=%b bl=%0d want 1 001 63", p_cmd_en, p_cmd_instr, p_cmd_bl);
        end
        step();
        p_rd_empty = 1'b0; p_rd_data = 32'h55;
        @(negedge clk);
        step();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (p_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_gate got p_rd_en=%b want 0", p_rd_en); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, p_rd_en} !== 2'b00) begin
            errors++; $display("FAIL rstmid_idle got busy=%b p_rd_en=%b want 0 0", busy, p_rd_en);
        end
        step();
        p_rd_empty = 1'b1;
        wr_base = wr_seen.size();
        req_stb = 1'b1; req_write = 1'b1; req_addr = 30'h10; req_len = 7'd2;
        @(negedge clk);
        checks++;
        if (req_ack !== 1'b1) begin errors++; $display("FAIL rstmid_ack got %b want 1", req_ack); end
        step();
        req_stb = 1'b0;
        for (int i = 0; i < 2; i++) begin
            usr_wr_valid = 1'b1; usr_wr_data = 32'(7 + i);
            @(negedge clk);
            step();
        end
        usr_wr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({p_cmd_en, p_cmd_bl, p_cmd_byte_addr} !== {1'b1, 6'd1, 30'h10}) begin
            errors++; $display("FAIL rstmid_cmd got en=%b bl=%0d addr=%h want 1 1 10", p_cmd_en, p_cmd_bl, p_cmd_byte_addr);
        end
        step();
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done got %b want 1", done); end
        step();
        checks++;
        if (wr_seen.size() - wr_base != 2 || wr_seen[wr_base] !== 32'd7 || wr_seen[wr_base + 1] !== 32'd8) begin
            errors++; $display("FAIL rstmid_data got %0d beats want 2 beats 7 8", wr_seen.size() - wr_base);
        end
    endtask

    initial begin
        int viol_base;
        #1;
        test_reset();
        viol_base = prot_viol;
        test_write4();
        test_read3();
        test_len64_stall();
        test_cmd_full();
        test_timeout();
        test_reset_mid();
        checks++;
        if (prot_viol != viol_base) begin
            errors++; $display("FAIL port_protocol got %0d violations want 0", prot_viol - viol_base);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule
